// File: rtl/text_slot_loader_pkg.sv
// -----------------------------------------------------------------------------
// text_slot_loader_pkg
// Shared constants and types for the text slot loader and any other text
// source that feeds the character-display effect stages.
//   SLOT_ID_W / NUM_SLOTS / IDX_W : bus geometry
//   BLANK_INDEX                   : glyph index of a space
//   state_t                       : loader FSM states
//   ASCII_*                       : printable / lower-case range limits
// No ports (package).
// -----------------------------------------------------------------------------
package text_slot_loader_pkg;

   localparam int SLOT_ID_W = 4;
   localparam int NUM_SLOTS = 7;
   localparam int IDX_W     = 7;
   localparam int PTR_W     = 3;

   localparam logic [IDX_W-1:0]     BLANK_INDEX = 7'h20;
   localparam logic [SLOT_ID_W-1:0] LAST_SLOT   = 4'd6;
   localparam logic [PTR_W-1:0]     LAST_PTR    = 3'd6;

   localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
   localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;
   localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
   localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      DRAIN  = 2'd2,
      COMMIT = 2'd3
   } state_t;

endpackage

// File: rtl/text_slot_loader_if.sv
// -----------------------------------------------------------------------------
// text_slot_loader_if
// Byte-stream handshake into the loader.
//   in_valid : source presents in_char
//   in_ready : loader accepts this cycle (transfer = in_valid && in_ready)
//   in_char  : ASCII byte
//   in_last  : in_char is the final byte of the message
// Modports: master (byte source), slave (loader).
// -----------------------------------------------------------------------------
interface text_slot_loader_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_char;
   logic       in_last;

   modport master (output in_valid, output in_char, output in_last, input in_ready);
   modport slave  (input in_valid, input in_char, input in_last, output in_ready);

endinterface

// File: rtl/text_slot_loader_ascii_to_glyph_index.sv
// -----------------------------------------------------------------------------
// ascii_to_glyph_index
// Combinational ASCII byte to glyph-index conversion. Non-printable codes,
// DEL and bytes with bit 7 set map to the blank glyph.
// Option macro TEXT_SLOT_LOADER_CASE_FOLD_EN: when defined, 'a'..'z' are
// folded to 'A'..'Z' because the glyph table only has upper-case shapes.
//   code  : input  8     ASCII byte
//   glyph : output IDX_W glyph index
// -----------------------------------------------------------------------------
module ascii_to_glyph_index
   import text_slot_loader_pkg::*;
(
   input  logic [7:0]       code,
   output logic [IDX_W-1:0] glyph
);

   // Printable-range filter with optional lower-to-upper fold
   always_comb begin
      glyph = BLANK_INDEX;
      if (code[7] || (code < ASCII_PRINT_LO) || (code > ASCII_PRINT_HI)) begin
         glyph = BLANK_INDEX;
      end else begin
`ifdef TEXT_SLOT_LOADER_CASE_FOLD_EN
         if ((code >= ASCII_LOWER_LO) && (code <= ASCII_LOWER_HI)) begin
            glyph = code[6:0] - 7'h20;
         end else begin
            glyph = code[6:0];
         end
`else
         glyph = code[6:0];
`endif
      end
   end

endmodule

// File: rtl/text_slot_loader.sv
// -----------------------------------------------------------------------------
// text_slot_loader
// Accepts a message as a byte stream, stores up to NUM_SLOTS glyph indices in
// a shadow buffer, commits complete messages atomically to an active buffer
// and broadcasts the active buffer one slot per clock on check/text_index.
// Option macro TEXT_SLOT_LOADER_CASE_FOLD_EN (see ascii_to_glyph_index).
//   clk        : input   system clock
//   rst_n      : input   synchronous active-low reset
//   in_bus     : slave   byte handshake (in_valid/in_ready/in_char/in_last)
//   clear      : input   abort fill and blank the active buffer
//   check      : output  slot id on the bus, 0..NUM_SLOTS-1
//   text_index : output  glyph index for slot check
//   loaded     : output  one-cycle pulse, first cycle the new message is live
//   busy       : output  high while filling, draining or committing
// -----------------------------------------------------------------------------
module text_slot_loader
   import text_slot_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   text_slot_loader_if.slave    in_bus,
   input  logic                 clear,
   output logic [SLOT_ID_W-1:0] check,
   output logic [IDX_W-1:0]     text_index,
   output logic                 loaded,
   output logic                 busy
);

   state_t                 state_r, state_s;
   logic [PTR_W-1:0]       ptr_r;
   logic [IDX_W-1:0]       shadow_r [NUM_SLOTS];
   logic [IDX_W-1:0]       active_r [NUM_SLOTS];
   logic [IDX_W-1:0]       active_s [NUM_SLOTS];
   logic [SLOT_ID_W-1:0]   check_r, check_s;
   logic [IDX_W-1:0]       text_index_r;
   logic                   loaded_r, busy_r, in_ready_r;
   logic                   accept_s, shadow_we_s;
   logic [IDX_W-1:0]       glyph_s;

   ascii_to_glyph_index u_conv (
      .code  (in_bus.in_char),
      .glyph (glyph_s)
   );

   assign accept_s        = in_bus.in_valid && in_ready_r;
   assign in_bus.in_ready = in_ready_r;
   assign check           = check_r;
   assign text_index      = text_index_r;
   assign loaded          = loaded_r;
   assign busy            = busy_r;

   // FSM next state and shadow write enable; clear drops any byte this cycle
   always_comb begin
      state_s     = state_r;
      shadow_we_s = 1'b0;
      if (clear) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  shadow_we_s = 1'b1;
                  state_s     = in_bus.in_last ? COMMIT : FILL;
               end else begin
                  state_s = IDLE;
               end
            end
            FILL: begin
               if (accept_s) begin
                  shadow_we_s = 1'b1;
                  if (in_bus.in_last) begin
                     state_s = COMMIT;
                  end else if (ptr_r == LAST_PTR) begin
                     state_s = DRAIN;
                  end else begin
                     state_s = FILL;
                  end
               end else begin
                  state_s = FILL;
               end
            end
            DRAIN: begin
               if (accept_s && in_bus.in_last) begin
                  state_s = COMMIT;
               end else begin
                  state_s = DRAIN;
               end
            end
            COMMIT:  state_s = IDLE;
            default: state_s = IDLE;
         endcase
      end
   end

   // Active buffer next value: blank on clear, shadow copy on commit
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         active_s[i] = active_r[i];
         if (clear) begin
            active_s[i] = BLANK_INDEX;
         end else if ((state_r == COMMIT) && (PTR_W'(i) < ptr_r)) begin
            active_s[i] = shadow_r[i];
         end else if (state_r == COMMIT) begin
            active_s[i] = BLANK_INDEX;
         end else begin
            active_s[i] = active_r[i];
         end
      end
   end

   // Scanner slot counter wraps after the last slot
   always_comb begin
      check_s = 4'd0;
      if (check_r >= LAST_SLOT) begin
         check_s = 4'd0;
      end else begin
         check_s = check_r + 4'd1;
      end
   end

   // State, buffers and registered outputs; the bus pair samples the
   // post-commit buffer so a commit shows up on the very next cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         ptr_r        <= 3'd0;
         check_r      <= 4'd0;
         text_index_r <= BLANK_INDEX;
         loaded_r     <= 1'b0;
         busy_r       <= 1'b0;
         in_ready_r   <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            shadow_r[i] <= BLANK_INDEX;
            active_r[i] <= BLANK_INDEX;
         end
      end else begin
         state_r      <= state_s;
         check_r      <= check_s;
         text_index_r <= active_s[check_s[2:0]];
         loaded_r     <= (state_r == COMMIT) && !clear;
         busy_r       <= (state_s != IDLE);
         in_ready_r   <= (state_s != COMMIT);
         for (int i = 0; i < NUM_SLOTS; i++) begin
            active_r[i] <= active_s[i];
         end
         if (clear || (state_r == COMMIT)) begin
            ptr_r <= 3'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
               shadow_r[i] <= BLANK_INDEX;
            end
         end else if (shadow_we_s) begin
            shadow_r[ptr_r] <= glyph_s;
            ptr_r           <= ptr_r + 3'd1;
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

endmodule

// File: tb/tb_text_slot_loader.sv
// -----------------------------------------------------------------------------
// tb_text_slot_loader
// Message-level reference model (queue of pending glyphs + commit flag) run
// alongside the loader, compared on every falling edge; directed messages
// from the test plan pin the model with literal slot contents, then a
// randomized phase with clear and reset injection.
// -----------------------------------------------------------------------------
module tb_text_slot_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic [3:0] check;
   logic [6:0] text_index;
   logic       loaded;
   logic       busy;

   text_slot_loader_if bus_if ();

   text_slot_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_bus     (bus_if),
      .clear      (clear),
      .check      (check),
      .text_index (text_index),
      .loaded     (loaded),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int loaded_seen = 0;

   // reference model state
   logic [6:0] m_active [7];
   int         m_q [$];
   bit         m_pending;
   bit         m_ready;
   bit         m_loaded;
   int         m_check;
   logic [6:0] m_tidx;
   bit         model_valid = 1'b0;

   logic [6:0] bus_slots [7];

   function automatic logic [6:0] conv(input logic [7:0] c);
      if (c[7] || c < 8'h20 || c == 8'h7F) return 7'h20;
`ifdef TEXT_SLOT_LOADER_CASE_FOLD_EN
      if (c >= 8'h61 && c <= 8'h7A) return c[6:0] - 7'h20;
`endif
      return c[6:0];
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         for (int i = 0; i < 7; i++) m_active[i] = 7'h20;
         m_q.delete();
         m_pending = 1'b0;
         m_ready   = 1'b0;
         m_loaded  = 1'b0;
         m_check   = 0;
         m_tidx    = 7'h20;
      end else begin
         m_loaded = 1'b0;
         if (clear) begin
            for (int i = 0; i < 7; i++) m_active[i] = 7'h20;
            m_q.delete();
            m_pending = 1'b0;
         end else if (m_pending) begin
            for (int i = 0; i < 7; i++)
               m_active[i] = (i < m_q.size()) ? 7'(m_q[i]) : 7'h20;
            m_q.delete();
            m_pending = 1'b0;
            m_loaded  = 1'b1;
         end else if (bus_if.in_valid && m_ready) begin
            if (m_q.size() < 7) m_q.push_back(int'(conv(bus_if.in_char)));
            if (bus_if.in_last) m_pending = 1'b1;
         end
         m_ready = !m_pending;
         m_check = (m_check + 1) % 7;
         m_tidx  = m_active[m_check];
      end
      model_valid = 1'b1;
   endtask

   // model advances on every active edge
   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // single compare process, every cycle once the model is defined
   initial begin
      forever begin
         @(negedge clk);
         if (model_valid) begin
            cmp("check", 32'(check), 32'(m_check));
            cmp("text_index", 32'(text_index), 32'(m_tidx));
            cmp("loaded", 32'(loaded), 32'(m_loaded));
            cmp("busy", 32'(busy), 32'(m_pending || m_q.size() > 0));
            cmp("in_ready", 32'(bus_if.in_ready), 32'(m_ready));
            if (loaded === 1'b1) loaded_seen++;
         end
      end
   end

   task automatic send_byte(input logic [7:0] c, input bit last, output int waits);
      bit acc;
      bus_if.in_valid = 1'b1;
      bus_if.in_char  = c;
      bus_if.in_last  = last;
      waits = 0;
      for (int k = 0; k < 50; k++) begin
         acc = bus_if.in_ready;
         @(negedge clk);
         if (acc) return;
         waits++;
      end
      cmp("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_msg(input string s);
      int w;
      for (int i = 0; i < s.len(); i++) send_byte(s[i], i == s.len() - 1, w);
      idle(2);
   endtask

   task automatic check_slots(input string nm, input logic [48:0] exp);
      repeat (7) begin
         bus_slots[check[2:0]] = text_index;
         @(negedge clk);
      end
      for (int i = 0; i < 7; i++) begin
         cmp(nm, 32'(bus_slots[i]), 32'(exp[(6-i)*7 +: 7]));
         cmp({nm, "_model"}, 32'(m_active[i]), 32'(exp[(6-i)*7 +: 7]));
      end
   endtask

   int lb, w;
   logic [6:0] fold_exp;

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.in_char  = 8'h00;
      bus_if.in_last  = 1'b0;
      repeat (3) @(negedge clk);
      cmp("rst_ready", 32'(bus_if.in_ready), 32'd0);
      cmp("rst_check", 32'(check), 32'd0);
      cmp("rst_tidx", 32'(text_index), 32'h20);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         cmp("scan_check", 32'(check), 32'(k % 7));
         cmp("scan_tidx", 32'(text_index), 32'h20);
      end

      // HELLO
      lb = loaded_seen;
      send_msg("HELLO");
      check_slots("hello", {7'h48, 7'h45, 7'h4C, 7'h4C, 7'h4F, 7'h20, 7'h20});
      cmp("hello_loaded", 32'(loaded_seen - lb), 32'd1);

      // overlong message drains H and I
      lb = loaded_seen;
      send_msg("ABCDEFGHI");
      check_slots("drain", {7'h41, 7'h42, 7'h43, 7'h44, 7'h45, 7'h46, 7'h47});
      cmp("drain_loaded", 32'(loaded_seen - lb), 32'd1);

      // valid held across COMMIT: one stall cycle, no loss
      lb = loaded_seen;
      send_byte(8'h58, 1'b1, w);
      send_byte(8'h59, 1'b1, w);
      cmp("bp_wait", 32'(w), 32'd1);
      idle(2);
      check_slots("bp", {7'h59, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20});
      cmp("bp_loaded", 32'(loaded_seen - lb), 32'd2);

      // clear mid-fill with a byte valid in the same cycle
      lb = loaded_seen;
      send_byte(8'h41, 1'b0, w);
      send_byte(8'h42, 1'b0, w);
      bus_if.in_char  = 8'h43;
      bus_if.in_last  = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      idle(3);
      check_slots("clear", {7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20});
      cmp("clear_loaded", 32'(loaded_seen - lb), 32'd0);
      send_msg("Z");
      check_slots("z", {7'h5A, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20});

      // lower case and control code
`ifdef TEXT_SLOT_LOADER_CASE_FOLD_EN
      fold_exp = 7'h41;
`else
      fold_exp = 7'h61;
`endif
      send_byte(8'h61, 1'b0, w);
      send_byte(8'h07, 1'b1, w);
      idle(2);
      check_slots("fold", {fold_exp, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20});

      // randomized traffic with clear and reset injection
      for (int n = 0; n < 4000; n++) begin
         bus_if.in_valid = ($urandom_range(0, 3) != 0);
         bus_if.in_char  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(32'h20, 32'h7F));
         bus_if.in_last  = ($urandom_range(0, 5) == 0);
         clear           = ($urandom_range(0, 80) == 0);
         rst_n           = ($urandom_range(0, 400) != 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      clear = 1'b0;
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
